// File: rtl/csr_state.sv
// Machine-mode CSR state: trap/mret sequencing, counters,
// interrupt arbitration and the one-cycle PC redirect pulse.
package csr_pkg;
    typedef logic [31:0] mcause_t;
    localparam mcause_t CAUSE_ILLEGAL_INSTR = 32'h0000_0002;
    localparam mcause_t CAUSE_ECALL_M       = 32'h0000_000B;
    localparam mcause_t CAUSE_MSI           = 32'h8000_0003;
    localparam mcause_t CAUSE_MTI           = 32'h8000_0007;
    localparam mcause_t CAUSE_MEI           = 32'h8000_000B;
endpackage

module csr_state
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic        mie_next,
    input  logic        mpie_next,
    input  logic        mtie_next,
    input  logic        msie_next,
    input  logic        meie_next,
    input  logic [29:0] mtvec_base_next,
    input  logic [63:0] mcycle_next,
    input  logic [63:0] minstret_next,
    input  logic        mcycle_inhibit_next,
    input  logic        minstret_inhibit_next,
    input  logic [31:0] mscratch_next,
    input  logic [31:0] mepc_next,
    input  logic [31:0] mtval_next,
    input  mcause_t     mcause_next,
    output logic        mie,
    output logic        mpie,
    output logic        mtie,
    output logic        msie,
    output logic        meie,
    output logic [29:0] mtvec_base,
    output logic [63:0] mcycle,
    output logic [63:0] minstret,
    output logic        mcycle_inhibit,
    output logic        minstret_inhibit,
    output logic [31:0] mscratch,
    output logic [31:0] mepc,
    output logic [31:0] mtval,
    output mcause_t     mcause,
    input  logic        mtip,
    input  logic        msip,
    input  logic        meip,
    input  logic        instr_retire,
    input  logic        trap_req,
    input  mcause_t     trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    output logic        irq_pending,
    output mcause_t     irq_cause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic {RUN, REDIR} state_t;

    state_t state_q, state_d;

    logic take_trap, take_mret, take_we;
    logic mie_d, mpie_d, mtie_d, msie_d, meie_d;
    logic [29:0] mtvec_base_d;
    logic [63:0] mcycle_d, minstret_d;
    logic mcycle_inh_d, minstret_inh_d;
    logic [31:0] mscratch_d, mepc_d, mtval_d;
    mcause_t mcause_d;
    logic [31:0] redirect_pc_d;
    logic mei, msi, mti;

    assign take_trap = (state_q == RUN) && trap_req;
    assign take_mret = (state_q == RUN) && mret_req && !trap_req;
    assign take_we   = (state_q == RUN) && csr_we
                       && !trap_req && !mret_req;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (take_trap || take_mret) state_d = REDIR;
            REDIR: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mie_d          = mie;
        mpie_d         = mpie;
        mtie_d         = mtie;
        msie_d         = msie;
        meie_d         = meie;
        mtvec_base_d   = mtvec_base;
        mcycle_inh_d   = mcycle_inhibit;
        minstret_inh_d = minstret_inhibit;
        mscratch_d     = mscratch;
        mepc_d         = mepc;
        mtval_d        = mtval;
        mcause_d       = mcause;
        redirect_pc_d  = redirect_pc;
        unique case (1'b1)
            take_trap: begin
                mepc_d        = {trap_pc[31:2], 2'b00};
                mcause_d      = trap_cause;
                mtval_d       = trap_tval;
                mpie_d        = mie;
                mie_d         = 1'b0;
                redirect_pc_d = {mtvec_base, 2'b00};
            end
            take_mret: begin
                mie_d         = mpie;
                mpie_d        = 1'b1;
                redirect_pc_d = mepc;
            end
            take_we: begin
                mie_d          = mie_next;
                mpie_d         = mpie_next;
                mtie_d         = mtie_next;
                msie_d         = msie_next;
                meie_d         = meie_next;
                mtvec_base_d   = mtvec_base_next;
                mcycle_inh_d   = mcycle_inhibit_next;
                minstret_inh_d = minstret_inhibit_next;
                mscratch_d     = mscratch_next;
                mepc_d         = mepc_next;
                mtval_d        = mtval_next;
                mcause_d       = mcause_next;
            end
            default: ;
        endcase
    end

    // Increments use the inhibit value held before this cycle's write
    always_comb begin
        mcycle_d   = mcycle;
        minstret_d = minstret;
        if (take_we)
            mcycle_d = mcycle_next;
        else if (!mcycle_inhibit)
            mcycle_d = mcycle + 64'd1;
        if (take_we)
            minstret_d = minstret_next;
        else if (instr_retire && !minstret_inhibit)
            minstret_d = minstret + 64'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            mie              <= 1'b0;
            mpie             <= 1'b0;
            mtie             <= 1'b0;
            msie             <= 1'b0;
            meie             <= 1'b0;
            mtvec_base       <= RESET_MTVEC[31:2];
            mcycle           <= 64'd0;
            minstret         <= 64'd0;
            mcycle_inhibit   <= 1'b0;
            minstret_inhibit <= 1'b0;
            mscratch         <= 32'd0;
            mepc             <= 32'd0;
            mtval            <= 32'd0;
            mcause           <= 32'd0;
            redirect_pc      <= 32'd0;
        end else begin
            state_q          <= state_d;
            mie              <= mie_d;
            mpie             <= mpie_d;
            mtie             <= mtie_d;
            msie             <= msie_d;
            meie             <= meie_d;
            mtvec_base       <= mtvec_base_d;
            mcycle           <= mcycle_d;
            minstret         <= minstret_d;
            mcycle_inhibit   <= mcycle_inh_d;
            minstret_inhibit <= minstret_inh_d;
            mscratch         <= mscratch_d;
            mepc             <= mepc_d;
            mtval            <= mtval_d;
            mcause           <= mcause_d;
            redirect_pc      <= redirect_pc_d;
        end
    end

    assign redirect_valid = (state_q == REDIR);

    assign mei = meip & meie;
    assign msi = msip & msie;
    assign mti = mtip & mtie;

    assign irq_pending = mie && (mei || msi || mti)
                         && (state_q == RUN);

    always_comb begin
        irq_cause = CAUSE_MTI;
        if (mei)
            irq_cause = CAUSE_MEI;
        else if (msi)
            irq_cause = CAUSE_MSI;
    end

endmodule
